// File: rtl/ms_dbio_arb.sv
// ms_dbio_arb -- two-requester arbiter for the 86-bit DBIO command bus.
//
// Requester 0 is the bring-up test sequencer and requester 1 is the host
// debug channel. Each granted command drives the bus for exactly one
// Issue phase. A gap of CGapLen idle cycles follows before the next
// arbitration.
//
// Parameters:
//   CGapLen       idle cycles after each issued command (0..15)
// Ports:
//   AClkH         system clock, rising edge
//   AResetH       synchronous reset, active-high
//   AClkHEn       clock enable; state advances only when 1
//   AReq0/1       requests, payload held stable until ack
//   AAddr0/1, AMosi0/1, AMosiIdx0/1, AMisoIdx0/1, AMosi1st0/1, AMiso1st0/1
//                 command payload per requester
//   AAck0/1       issue acknowledge; held through disabled cycles, so the
//                 requester consumes it only when AClkHEn=1
//   ADbio*        bus outputs, all zero outside Issue
//   ABusy         arbiter not in Idle
//   AOwner        index of the last granted requester
//
// Configuration macro:
//   MS_DBIO_ARB_PRIO_EN  fixed priority (requester 0 always wins a tie);
//                        undefined gives round-robin.
module ms_dbio_arb #(
  parameter int unsigned CGapLen = 2
) (
  input  logic        AClkH,
  input  logic        AResetH,
  input  logic        AClkHEn,
  input  logic        AReq0,
  input  logic        AReq1,
  input  logic [11:0] AAddr0,
  input  logic [11:0] AAddr1,
  input  logic [63:0] AMosi0,
  input  logic [63:0] AMosi1,
  input  logic [3:0]  AMosiIdx0,
  input  logic [3:0]  AMosiIdx1,
  input  logic [3:0]  AMisoIdx0,
  input  logic [3:0]  AMisoIdx1,
  input  logic        AMosi1st0,
  input  logic        AMosi1st1,
  input  logic        AMiso1st0,
  input  logic        AMiso1st1,
  output logic        AAck0,
  output logic        AAck1,
  output logic [11:0] ADbioAddr,
  output logic [63:0] ADbioMosi,
  output logic [3:0]  ADbioMosiIdx,
  output logic [3:0]  ADbioMisoIdx,
  output logic        ADbioMosi1st,
  output logic        ADbioMiso1st,
  output logic        ABusy,
  output logic        AOwner
);

  typedef enum logic [2:0] {
    SIdle  = 3'b001,
    SIssue = 3'b010,
    SGap   = 3'b100
  } stateT;

  localparam logic [3:0] GapInit = (CGapLen == 0) ? 4'd0 : 4'(CGapLen - 1);

  stateT       FState, NState;
  logic [3:0]  FCnt, NCnt;
  logic        FOwner, NOwner;
  logic        winner;
  logic        load;

  logic [11:0] FAddr;
  logic [63:0] FMosi;
  logic [3:0]  FMosiIdx, FMisoIdx;
  logic        FMosi1st, FMiso1st;

  always_comb begin
`ifdef MS_DBIO_ARB_PRIO_EN
    winner = ~AReq0;
`else
    // On a tie the requester that did not win last time goes next.
    winner = (AReq0 & AReq1) ? ~FOwner : ~AReq0;
`endif
  end

  always_comb begin
    NState = FState;
    NCnt   = FCnt;
    NOwner = FOwner;
    load   = 1'b0;
    unique case (FState)
      SIdle: begin
        if (AReq0 | AReq1) begin
          load   = 1'b1;
          NOwner = winner;
          NState = SIssue;
        end
      end
      SIssue: begin
        if (CGapLen == 0) begin
          NState = SIdle;
        end else begin
          NState = SGap;
          NCnt   = GapInit;
        end
      end
      SGap: begin
        if (FCnt == 4'd0) NState = SIdle;
        else              NCnt   = FCnt - 4'd1;
      end
      default: NState = SIdle;
    endcase
  end

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      FState   <= SIdle;
      FCnt     <= '0;
      FOwner   <= 1'b1;
      FAddr    <= '0;
      FMosi    <= '0;
      FMosiIdx <= '0;
      FMisoIdx <= '0;
      FMosi1st <= 1'b0;
      FMiso1st <= 1'b0;
    end else if (AClkHEn) begin
      FState <= NState;
      FCnt   <= NCnt;
      FOwner <= NOwner;
      if (load) begin
        FAddr    <= winner ? AAddr1    : AAddr0;
        FMosi    <= winner ? AMosi1    : AMosi0;
        FMosiIdx <= winner ? AMosiIdx1 : AMosiIdx0;
        FMisoIdx <= winner ? AMisoIdx1 : AMisoIdx0;
        FMosi1st <= winner ? AMosi1st1 : AMosi1st0;
        FMiso1st <= winner ? AMiso1st1 : AMiso1st0;
      end
    end
  end

  logic issuing;
  assign issuing = (FState == SIssue);

  // OR-bus: every field is forced to zero outside Issue.
  assign ADbioAddr    = issuing ? FAddr    : '0;
  assign ADbioMosi    = issuing ? FMosi    : '0;
  assign ADbioMosiIdx = issuing ? FMosiIdx : '0;
  assign ADbioMisoIdx = issuing ? FMisoIdx : '0;
  assign ADbioMosi1st = issuing & FMosi1st;
  assign ADbioMiso1st = issuing & FMiso1st;
  assign AAck0        = issuing & ~FOwner;
  assign AAck1        = issuing & FOwner;
  assign ABusy        = (FState != SIdle);
  assign AOwner       = FOwner;

endmodule
